// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the combinational program ROM and
// presents one instruction at a time to decode over a valid/ready handshake.
//
// state  | meaning
// IDLE   | after reset, no fetching until start
// RUN    | fetching, up to one instruction per cycle
// DRAIN  | halt seen, waiting for decode to take the pending IR
// HALTED | stopped, resumes at current pc on start with halt low
module fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               halt,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [4:0]         opcode,
  output logic [2:0]         rd,
  output logic [7:0]         imm,
  output logic               running
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] ir;
  logic [ADDR_W-1:0]  ir_pc;
  logic               ir_valid;
  logic               take;
  logic               slot_free;
  logic               fetch;

  assign take      = ir_valid & instr_ready;
  assign slot_free = ~ir_valid | take;
  // A redirect or a pending halt suppresses the fetch so the IR ends up empty.
  assign fetch     = (state == RUN) & ~halt & slot_free & ~redirect;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (halt) state_nxt = (slot_free | redirect) ? HALTED : DRAIN;
      DRAIN:   if (slot_free | redirect) state_nxt = HALTED;
      HALTED:  if (!halt && start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else if (redirect) begin
      pc       <= redirect_pc;
      ir_valid <= 1'b0;
    end else if (fetch) begin
      ir       <= rom_data;
      ir_pc    <= pc;
      ir_valid <= 1'b1;
      pc       <= pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else if (take) begin
      ir_valid <= 1'b0;
    end
  end

  assign rom_addr    = pc;
  assign instr_valid = ir_valid;
  assign instr       = ir;
  assign instr_pc    = ir_pc;
  assign opcode      = ir[15:11];
  assign rd          = ir[10:8];
  assign imm         = ir[7:0];
  assign running     = (state == RUN);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; the ROM holds {addr+8, addr+1} at every address.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, start, halt, redirect, instr_ready;
  logic [7:0]  rom_addr, redirect_pc, instr_pc, imm;
  logic [15:0] rom_data, instr;
  logic        instr_valid, running;
  logic [4:0]  opcode;
  logic [2:0]  rd;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb rom_data = {rom_addr + 8'h08, rom_addr + 8'h01};

  fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc),
    .opcode(opcode), .rd(rd), .imm(imm), .running(running)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ir(input string tag, input logic [15:0] ei, input logic [7:0] ep);
    chk({tag, ".valid"}, 32'(instr_valid), 32'd1);
    chk({tag, ".instr"}, 32'(instr), 32'(ei));
    chk({tag, ".pc"}, 32'(instr_pc), 32'(ep));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt = 1'b0; redirect = 1'b0;
    redirect_pc = 8'h00; instr_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("rst.valid", 32'(instr_valid), 32'd0);
    chk("rst.addr", 32'(rom_addr), 32'h00);
    chk("rst.running", 32'(running), 32'd0);
    chk("rst.instr", 32'(instr), 32'h0);
    chk("rst.instr_pc", 32'(instr_pc), 32'h0);
    step();
    chk("idle.addr", 32'(rom_addr), 32'h00);
    chk("idle.valid", 32'(instr_valid), 32'd0);

    // start: RUN next cycle, first instruction the cycle after
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start.running", 32'(running), 32'd1);
    chk("start.valid", 32'(instr_valid), 32'd0);
    step(); chk_ir("seq0", 16'h0801, 8'h00);
    chk("seq0.opcode", 32'(opcode), 32'd1);
    chk("seq0.rd", 32'(rd), 32'd0);
    chk("seq0.imm", 32'(imm), 32'h01);
    step(); chk_ir("seq1", 16'h0902, 8'h01);
    chk("seq1.rd", 32'(rd), 32'd1);
    step(); chk_ir("seq2", 16'h0A03, 8'h02);

    // stall 3 cycles on ROM[2]
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_ir("stall", 16'h0A03, 8'h02);
      chk("stall.addr", 32'(rom_addr), 32'h03);
    end
    instr_ready = 1'b1;
    step(); chk_ir("unstall3", 16'h0B04, 8'h03);
    step(); chk_ir("unstall4", 16'h0C05, 8'h04);

    // wrap at 0xFF
    redirect = 1'b1; redirect_pc = 8'hFE;
    step();
    redirect = 1'b0;
    chk("wrap.flush", 32'(instr_valid), 32'd0);
    chk("wrap.addr", 32'(rom_addr), 32'hFE);
    step(); chk_ir("wrapFE", 16'h06FF, 8'hFE);
    step(); chk_ir("wrapFF", 16'h0700, 8'hFF);
    chk("wrap.addr0", 32'(rom_addr), 32'h00);
    step(); chk_ir("wrap00", 16'h0801, 8'h00);
    step(); chk_ir("wrap01", 16'h0902, 8'h01);

    // redirect during a stall on 0x0E
    redirect = 1'b1; redirect_pc = 8'h0E;
    step();
    redirect = 1'b0;
    step(); chk_ir("ir0E", 16'h160F, 8'h0E);
    instr_ready = 1'b0;
    step(); chk_ir("ir0E.hold", 16'h160F, 8'h0E);
    redirect = 1'b1; redirect_pc = 8'h0D;
    step();
    redirect = 1'b0;
    chk("redir.valid", 32'(instr_valid), 32'd0);
    chk("redir.addr", 32'(rom_addr), 32'h0D);
    step(); chk_ir("redir0D", 16'h150E, 8'h0D);
    instr_ready = 1'b1;
    step(); chk_ir("redir0E", 16'h160F, 8'h0E);

    // halt while stalled -> DRAIN, then HALTED once taken
    instr_ready = 1'b0;
    step(); chk_ir("pre_halt", 16'h160F, 8'h0E);
    halt = 1'b1;
    step();
    chk("drain.running", 32'(running), 32'd0);
    chk_ir("drain", 16'h160F, 8'h0E);
    chk("drain.addr", 32'(rom_addr), 32'h0F);
    instr_ready = 1'b1;
    step();
    chk("halted.valid", 32'(instr_valid), 32'd0);
    chk("halted.running", 32'(running), 32'd0);
    chk("halted.addr", 32'(rom_addr), 32'h0F);
    step();
    chk("halted2.valid", 32'(instr_valid), 32'd0);
    chk("halted2.addr", 32'(rom_addr), 32'h0F);
    halt = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("resume.running", 32'(running), 32'd1);
    step(); chk_ir("resume0F", 16'h1710, 8'h0F);

    // reset during a stall
    instr_ready = 1'b0;
    step(); chk_ir("rstall", 16'h1710, 8'h0F);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst.valid", 32'(instr_valid), 32'd0);
    chk("mrst.addr", 32'(rom_addr), 32'h00);
    chk("mrst.running", 32'(running), 32'd0);
    instr_ready = 1'b1;
    step(); step();
    chk("mrst.nofetch", 32'(instr_valid), 32'd0);
    chk("mrst.addr2", 32'(rom_addr), 32'h00);

    // halt and redirect together -> HALTED with IR flushed
    start = 1'b1;
    step();
    start = 1'b0;
    step(); chk_ir("hr0", 16'h0801, 8'h00);
    halt = 1'b1; redirect = 1'b1; redirect_pc = 8'h40;
    step();
    redirect = 1'b0;
    chk("hr.running", 32'(running), 32'd0);
    chk("hr.valid", 32'(instr_valid), 32'd0);
    chk("hr.addr", 32'(rom_addr), 32'h40);
    step();
    chk("hr.stay", 32'(running), 32'd0);
    chk("hr.addr2", 32'(rom_addr), 32'h40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the decode/control unit and drives the combinational program ROM (`memory`).
- Holds the program counter and drives the ROM address.
- Latches the returned 16-bit instruction into an instruction register and hands it to decode over a valid/ready handshake.
- Accepts jump/branch redirects from control (JMP, taken BRXX) and flushes the in-flight instruction.

Parameters:
- ADDR_W, 8, program address width (ROM depth 2^ADDR_W).
- INSTR_W, 16, instruction width; fields are opcode[15:11], reg[10:8], imm[7:0].
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; leaves IDLE and begins fetching.
- halt  input  1  level; stop fetching after the current IR is consumed.
- rom_addr  output  ADDR_W  address to program ROM; equals pc register.
- rom_data  input  INSTR_W  instruction from combinational ROM; valid in the same cycle as rom_addr.
- redirect  input  1  one-cycle pulse from control; load redirect_pc and flush.
- redirect_pc  input  ADDR_W  branch/jump target.
- instr_valid  output  1  IR holds an instruction for decode.
- instr_ready  input  1  decode accepts IR this cycle.
- instr  output  INSTR_W  IR contents.
- instr_pc  output  ADDR_W  address the IR instruction was fetched from.
- opcode  output  5  instr[15:11].
- rd  output  3  instr[10:8].
- imm  output  8  instr[7:0].
- running  output  1  FSM is in RUN.

Behaviour:
- Registers: pc, ir, ir_pc, ir_valid, state. opcode, rd and imm are combinational slices of ir. rom_addr = pc.
- Reset (synchronous, wins over every other input): pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, state=IDLE. All outputs therefore read 0, except rom_addr, which reads RESET_PC.
- FSM states IDLE, RUN, DRAIN, HALTED.
  - IDLE: no fetch. start -> RUN. A redirect in IDLE loads pc and stays in IDLE.
  - RUN: fetch as described below.
    - halt=1 and (ir_valid=0 or take) -> HALTED.
    - halt=1 otherwise -> DRAIN.
  - DRAIN: no new fetch. When ir_valid=0 or take -> HALTED.
  - HALTED: no fetch. halt=0 and start -> RUN, resuming at the current pc.
- take = ir_valid & instr_ready. A slot is free when ir_valid=0 or take.
- Fetch in RUN with a free slot and no redirect: ir<=rom_data, ir_pc<=pc, ir_valid<=1, pc<=pc+1.
- Latency: instruction at address A appears on instr one cycle after pc=A. Sustained throughput is 1 instruction/cycle while instr_ready=1.
- Stall: ir_valid=1 and instr_ready=0 -> ir, ir_pc and pc hold. instr must stay stable until taken.
- Redirect (any state except reset; priority over fetch and stall):
  - pc<=redirect_pc and ir_valid<=0. The instruction at the old pc is discarded.
  - If take coincides with redirect, the IR instruction counts as consumed. Redirect is issued by control as a result of that instruction.
  - First post-redirect instruction appears 2 cycles after the redirect pulse: cycle 1 fetches it, cycle 2 presents it.
- Arithmetic: pc+1 is modulo 2^ADDR_W. 0xFF wraps to 0x00 with no flag.
- halt and redirect in the same cycle: the redirect is applied (pc loaded, IR flushed) and the FSM goes to HALTED directly, since IR is now empty.
- start while in RUN/DRAIN: ignored.
- Reset mid-stall or mid-redirect: reset values apply next cycle. Any pending IR is lost.
- No combinational path from instr_ready to rom_addr. rom_addr depends on the pc register only.

Test Plan:
- Reset then start, ROM[0..3] = 16'h0801, 16'h0902, 16'h0A03, 16'h0B04, instr_ready=1 -> instr_valid rises 1 cycle after start's fetch. instr/instr_pc = 0801/00, 0902/01, 0A03/02, 0B04/03 on consecutive cycles.
- instr_ready=0 for 3 cycles while instr=ROM[2] -> instr, instr_pc=02 and rom_addr=03 held all 3 cycles. ROM[3] is presented the cycle after ready returns; no skips or duplicates.
- redirect=1, redirect_pc=8'h0D while IR holds ROM[0x0E] and instr_ready=0 -> next cycle instr_valid=0, rom_addr=0D. The following cycle instr_pc=0D; 0x0E is not re-presented before 0x0D.
- pc=8'hFE running freely -> instr_pc sequence FE, FF, 00, 01. rom_addr wraps to 00.
- halt=1 while instr_valid=1 and instr_ready=0 -> state DRAIN, no pc change. After instr_ready=1 for one cycle: running=0, instr_valid=0, pc unchanged. start with halt=0 resumes at that pc.
- Assert reset for 1 cycle during a stall with instr_valid=1 -> next cycle instr_valid=0, rom_addr=RESET_PC, running=0. No fetch until start.
